// File: rtl/loader_pkg.sv
// Shared types and bit-timing helper for the serial instruction loader.
package loader_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} ld_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Instruction-memory write port driven by the loader.
interface instr_loader_if #(
  parameter int ADDR_W = 8
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  modport master (output we, waddr, wdata);
  modport slave  (input  we, waddr, wdata);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop input sync, mid-bit sampling, one-cycle byte/stop-error pulses.
module uart_rx_core
  import loader_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err
);

  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);

  logic [1:0]    sync_q;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: if (cnt_q == CW'(HALF - 1)) begin
        // a start bit that is already high again at its centre is a glitch
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == CW'(CPB - 1)) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == CW'(CPB - 1)) begin
        cnt_d   = '0;
        valid_d = rx_s;
        err_d   = !rx_s;
        state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign stop_err   = err_q;

endmodule

// File: rtl/instr_loader.sv
// Packs received bytes MSB-first into 32-bit words and writes N_WORDS of them
// to consecutive instruction-memory addresses after each start pulse.
module instr_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 8,
  parameter int N_WORDS  = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rxd,
  input  logic           start,
  instr_loader_if.master mem,
  output logic           busy,
  output logic           done,
  output logic           frame_err
);

  localparam int WCW = ADDR_W + 1;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       stop_err;

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stop_err   (stop_err)
  );

  ld_state_t         state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [31:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ferr_q, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= L_IDLE;
      bcnt_q  <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ferr_d  = ferr_q;
    if (start) begin
      // start from any state (re)arms a load and drops any partial word
      state_d = L_LOAD;
      bcnt_d  = '0;
      addr_d  = '0;
      wcnt_d  = '0;
      asm_d   = '0;
      ferr_d  = 1'b0;
    end else if (state_q == L_LOAD) begin
      if (stop_err) ferr_d = 1'b1;
      if (byte_valid) begin
        asm_d  = {asm_q[23:0], byte_data};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {asm_q[23:0], byte_data};
          addr_d  = addr_q + ADDR_W'(1);
          wcnt_d  = wcnt_q + WCW'(1);
        end
      end
      // leave one cycle after the final strobe so done trails we
      if (we_q && wcnt_q == WCW'(N_WORDS)) state_d = L_DONE;
    end
  end

  assign mem.we    = we_q;
  assign mem.waddr = waddr_q;
  assign mem.wdata = wdata_q;
  assign busy      = (state_q == L_LOAD);
  assign done      = (state_q == L_DONE);
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench: three loaders (spec timing, fast timing, 2-bit address wrap)
// driven by a serial bit driver and checked against a word-level reference model.
module tb_instr_loader;

  logic       clk = 1'b0;
  logic [2:0] rst = 3'b111;
  logic [2:0] rxd = 3'b111;
  logic [2:0] start = 3'b000;
  logic [2:0] busy_w, done_w, ferr_w, wev;
  logic [7:0]  wa [3];
  logic [31:0] wd [3];

  always #5 clk = ~clk;

  instr_loader_if #(.ADDR_W(8)) ifa ();
  instr_loader_if #(.ADDR_W(8)) ifb ();
  instr_loader_if #(.ADDR_W(2)) ifc ();

  instr_loader #(.CLK_FREQ(50_000_000), .BAUD(115200), .ADDR_W(8), .N_WORDS(2)) dut_a (
    .clk(clk), .rst(rst[0]), .rxd(rxd[0]), .start(start[0]), .mem(ifa),
    .busy(busy_w[0]), .done(done_w[0]), .frame_err(ferr_w[0]));
  instr_loader #(.CLK_FREQ(1_152_000), .BAUD(115200), .ADDR_W(8), .N_WORDS(2)) dut_b (
    .clk(clk), .rst(rst[1]), .rxd(rxd[1]), .start(start[1]), .mem(ifb),
    .busy(busy_w[1]), .done(done_w[1]), .frame_err(ferr_w[1]));
  instr_loader #(.CLK_FREQ(1_152_000), .BAUD(115200), .ADDR_W(2), .N_WORDS(4)) dut_c (
    .clk(clk), .rst(rst[2]), .rxd(rxd[2]), .start(start[2]), .mem(ifc),
    .busy(busy_w[2]), .done(done_w[2]), .frame_err(ferr_w[2]));

  assign wev[0] = ifa.we;  assign wa[0] = ifa.waddr;        assign wd[0] = ifa.wdata;
  assign wev[1] = ifb.we;  assign wa[1] = ifb.waddr;        assign wd[1] = ifb.wdata;
  assign wev[2] = ifc.we;  assign wa[2] = {6'b0, ifc.waddr}; assign wd[2] = ifc.wdata;

  // reference model: per-DUT load state at the word level
  int cpb [3] = '{434, 10, 10};
  int nw  [3] = '{2, 2, 4};
  int aw  [3] = '{8, 8, 2};
  localparam int LAT_A = 4 + 217 + 9 * 434;

  bit          m_armed [3];
  bit          m_done  [3];
  bit          m_ferr  [3];
  int          m_nb    [3];
  int          m_addr  [3];
  int          m_words [3];
  logic [31:0] m_acc   [3];

  typedef struct { logic [7:0] addr; logic [31:0] data; bit last; } wr_t;
  typedef struct { int d; int kind; bit busy; bit done; bit ferr; } st_t;
  wr_t   exp_q [3][$];
  st_t   st_q [$];
  string nm_q [$];

  int cyc = 0;
  int t0 [3];
  bit dchk [3];
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc++;

  // monitor: all comparisons happen here, away from the rising edge
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (dchk[d]) begin
        dchk[d] = 1'b0;
        checks++;
        if (!(done_w[d] && !busy_w[d])) begin
          errors++;
          $display("FAIL done_after_last_we dut%0d: got done=%0b busy=%0b expected done=1 busy=0",
                   d, done_w[d], busy_w[d]);
        end
      end
      if (wev[d]) begin
        checks++;
        if (exp_q[d].size() == 0) begin
          errors++;
          $display("FAIL unexpected_write dut%0d: got addr=%0h data=%h expected no write", d, wa[d], wd[d]);
        end else begin
          wr_t e;
          e = exp_q[d].pop_front();
          if (wa[d] !== e.addr || wd[d] !== e.data) begin
            errors++;
            $display("FAIL write dut%0d: got addr=%0h data=%h expected addr=%0h data=%h",
                     d, wa[d], wd[d], e.addr, e.data);
          end
          if (d == 0) begin
            checks++;
            if (cyc - t0[0] != LAT_A) begin
              errors++;
              $display("FAIL write_latency dut0: got %0d cycles expected %0d", cyc - t0[0], LAT_A);
            end
          end
          if (e.last) dchk[d] = 1'b1;
        end
      end
    end
    while (st_q.size() > 0) begin
      st_t r;
      string nm;
      r  = st_q.pop_front();
      nm = nm_q.pop_front();
      checks++;
      case (r.kind)
        0: if (busy_w[r.d] !== r.busy || done_w[r.d] !== r.done || ferr_w[r.d] !== r.ferr) begin
             errors++;
             $display("FAIL %s dut%0d: got busy=%0b done=%0b ferr=%0b expected busy=%0b done=%0b ferr=%0b",
                      nm, r.d, busy_w[r.d], done_w[r.d], ferr_w[r.d], r.busy, r.done, r.ferr);
           end
        1: if ({wev[r.d], wa[r.d], wd[r.d], busy_w[r.d], done_w[r.d], ferr_w[r.d]} !== '0) begin
             errors++;
             $display("FAIL %s dut%0d: got we=%0b waddr=%0h wdata=%h busy=%0b done=%0b ferr=%0b expected all zero",
                      nm, r.d, wev[r.d], wa[r.d], wd[r.d], busy_w[r.d], done_w[r.d], ferr_w[r.d]);
           end
        default: if (exp_q[r.d].size() != 0) begin
             errors++;
             $display("FAIL %s dut%0d: got %0d writes outstanding expected 0", nm, r.d, exp_q[r.d].size());
           end
      endcase
    end
  end

  task automatic push_req(input int d, input int kind, input string nm);
    st_t r;
    r.d = d; r.kind = kind; r.busy = m_armed[d]; r.done = m_done[d]; r.ferr = m_ferr[d];
    st_q.push_back(r);
    nm_q.push_back(nm);
  endtask

  task automatic check_status(input int d, input int kind, input string nm);
    @(posedge clk); #1 push_req(d, kind, nm);
    @(negedge clk);
  endtask

  task automatic model_clear(input int d, input bit armed);
    m_armed[d] = armed; m_done[d] = 1'b0; m_ferr[d] = 1'b0;
    m_nb[d] = 0; m_addr[d] = 0; m_words[d] = 0; m_acc[d] = '0;
  endtask

  task automatic model_byte(input int d, input logic [7:0] b, input bit good);
    wr_t e;
    if (!m_armed[d]) return;
    if (!good) begin
      m_ferr[d] = 1'b1;
      return;
    end
    m_acc[d] = (m_acc[d] << 8) | 32'(b);
    m_nb[d]++;
    if (m_nb[d] == 4) begin
      m_nb[d]  = 0;
      e.addr   = 8'(m_addr[d] % (1 << aw[d]));
      e.data   = m_acc[d];
      m_words[d]++;
      e.last   = (m_words[d] == nw[d]);
      exp_q[d].push_back(e);
      m_addr[d]++;
      if (e.last) begin
        m_armed[d] = 1'b0;
        m_done[d]  = 1'b1;
      end
    end
  endtask

  // all stimulus tasks start and end on a falling edge
  task automatic do_start(input int d);
    start[d] = 1'b1;
    model_clear(d, 1'b1);
    @(posedge clk); #1 push_req(d, 0, "busy_on_start");
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input bit good, input int gap);
    model_byte(d, b, good);
    rxd[d] = 1'b0;
    t0[d]  = cyc;
    repeat (cpb[d]) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd[d] = b[i];
      repeat (cpb[d]) @(negedge clk);
    end
    rxd[d] = good;
    repeat (cpb[d]) @(negedge clk);
    rxd[d] = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  logic [7:0] basic [8] = '{8'h20, 8'h08, 8'h00, 8'h07, 8'h8C, 8'h02, 8'h00, 8'h00};
  logic [7:0] fe_ok [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] rs_ok [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  initial begin
    for (int d = 0; d < 3; d++) model_clear(d, 1'b0);
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) push_req(d, 1, "reset_values");
    @(negedge clk);
    rst = 3'b000;
    repeat (4) @(negedge clk);

    // DUT A at full-rate timing: glitch rejection, back-to-back basic load, ignored byte in done
    do_start(0);
    rxd[0] = 1'b0;
    repeat (100) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (600) @(negedge clk);
    check_status(0, 0, "after_glitch");
    for (int i = 0; i < 8; i++) send_byte(0, basic[i], 1'b1, 0);
    repeat (4) @(negedge clk);
    check_status(0, 0, "basic_done");
    send_byte(0, 8'h5A, 1'b1, 20);
    check_status(0, 0, "ignored_in_done");

    // DUT B: frame error, restart discarding a partial word, reset mid-word, idle bytes, random load
    do_start(1);
    send_byte(1, 8'h55, 1'b0, 20);
    check_status(1, 0, "frame_err_set");
    for (int i = 0; i < 4; i++) send_byte(1, fe_ok[i], 1'b1, 0);
    check_status(1, 0, "after_frame_err_word");
    do_start(1);
    send_byte(1, 8'h11, 1'b1, 0);
    send_byte(1, 8'h22, 1'b1, 0);
    send_byte(1, 8'h33, 1'b1, 5);
    do_start(1);
    for (int i = 0; i < 4; i++) send_byte(1, rs_ok[i], 1'b1, 0);
    send_byte(1, 8'h55, 1'b0, 20);
    send_byte(1, 8'h01, 1'b1, 0);
    send_byte(1, 8'h02, 1'b1, 0);
    send_byte(1, 8'h03, 1'b1, 0);
    check_status(1, 0, "pre_reset_status");
    rxd[1] = 1'b0;
    repeat (cpb[1]) @(negedge clk);
    rxd[1] = 1'b0;
    repeat (cpb[1]) @(negedge clk);
    rxd[1] = 1'b1;
    repeat (cpb[1] / 2) @(negedge clk);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    model_clear(1, 1'b0);
    push_req(1, 1, "reset_mid_word");
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst[1] = 1'b0;
    repeat (30) @(negedge clk);
    send_byte(1, 8'h77, 1'b1, 20);
    check_status(1, 0, "ignored_in_idle");
    do_start(1);
    for (int i = 0; i < 8; i++) send_byte(1, 8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, 3));
    repeat (4) @(negedge clk);
    check_status(1, 0, "random_load_done");

    // DUT C: 2-bit address, four words wrap to 3, then a second load starts back at 0
    for (int pass = 0; pass < 2; pass++) begin
      do_start(2);
      for (int i = 0; i < 16; i++) send_byte(2, 8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, 2));
      repeat (4) @(negedge clk);
      check_status(2, 0, "wrap_load_done");
    end

    for (int d = 0; d < 3; d++) check_status(d, 2, "writes_drained");
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout at %0t expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
